// File: rtl/bcd_scan_ctrl_if.sv
// Bus bundle between the clock counters, the shared
// binary-to-BCD converter and the display scan logic.
interface bcd_scan_ctrl_if;
    logic [7:0]  hour;
    logic [7:0]  min;
    logic [7:0]  sec;
    logic [7:0]  conv_bin;
    logic [7:0]  conv_bcd;
    logic [23:0] bcd_hms;
    logic        upd_done;
    logic        range_err;
    logic [5:0]  an;
    logic [3:0]  digit;

    modport master (
        output hour, min, sec, conv_bcd,
        input  conv_bin, bcd_hms, upd_done,
        input  range_err, an, digit
    );

    modport slave (
        input  hour, min, sec, conv_bcd,
        output conv_bin, bcd_hms, upd_done,
        output range_err, an, digit
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// Time-shares one binary-to-BCD converter over h/m/s
// and scans the six-digit BCD image onto the display.
module bcd_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input logic           clk,
    input logic           rst_n,
    bcd_scan_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CONV_S = 3'd1;
    localparam logic [2:0] CONV_M = 3'd2;
    localparam logic [2:0] CONV_H = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [2:0]    r_state;
    logic [7:0]    r_snap_h;
    logic [7:0]    r_snap_m;
    logic [7:0]    r_snap_s;
    logic [23:0]   r_bcd;
    logic          r_upd;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [5:0]    r_an;
    logic [3:0]    r_digit;

    logic [7:0]    w_op;
    logic          w_ovr;
    logic [7:0]    w_conv;
    logic [3:0]    w_nib;

    // Select the snapshot operand for this phase and clamp it.
    always_comb begin
        w_op = 8'd0;
        case (r_state)
            CONV_S:  w_op = r_snap_s;
            CONV_M:  w_op = r_snap_m;
            CONV_H:  w_op = r_snap_h;
            default: w_op = 8'd0;
        endcase
        w_ovr  = (w_op > 8'd99);
        w_conv = w_ovr ? 8'd99 : w_op;
    end

    // Nibble of the BCD image belonging to the current scan slot.
    always_comb begin
        w_nib = 4'd0;
        case (r_idx)
            3'd0:    w_nib = r_bcd[3:0];
            3'd1:    w_nib = r_bcd[7:4];
            3'd2:    w_nib = r_bcd[11:8];
            3'd3:    w_nib = r_bcd[15:12];
            3'd4:    w_nib = r_bcd[19:16];
            3'd5:    w_nib = r_bcd[23:20];
            default: w_nib = 4'd0;
        endcase
    end

    // Update sequencer: snapshot on change, then s, m, h.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_snap_h <= 8'hFF;
            r_snap_m <= 8'hFF;
            r_snap_s <= 8'hFF;
            r_bcd    <= 24'd0;
            r_upd    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_upd <= (r_state == CONV_H);
            if (w_ovr) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if ({bus.hour, bus.min, bus.sec} !=
                        {r_snap_h, r_snap_m, r_snap_s}) begin
                        r_snap_h <= bus.hour;
                        r_snap_m <= bus.min;
                        r_snap_s <= bus.sec;
                        r_state  <= CONV_S;
                    end
                end
                CONV_S: begin
                    r_bcd[7:0] <= bus.conv_bcd;
                    r_state    <= CONV_M;
                end
                CONV_M: begin
                    r_bcd[15:8] <= bus.conv_bcd;
                    r_state     <= CONV_H;
                end
                CONV_H: begin
                    r_bcd[23:16] <= bus.conv_bcd;
                    r_state      <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan engine: an and digit only change on slot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_an    <= 6'b111111;
            r_digit <= 4'd0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            r_an    <= ~(6'b000001 << r_idx);
            r_digit <= w_nib;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.conv_bin  = w_conv;
    assign bus.bcd_hms   = r_bcd;
    assign bus.upd_done  = r_upd;
    assign bus.range_err = r_err;
    assign bus.an        = r_an;
    assign bus.digit     = r_digit;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with a timeline-based
// reference model checked every cycle.
module tb_bcd_scan_ctrl;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    bcd_scan_ctrl_if bus ();

    bcd_scan_ctrl #(.SCAN_DIV(D)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // External converter: plain decimal split.
    assign bus.conv_bcd = {4'(bus.conv_bin / 8'd10),
                           4'(bus.conv_bin % 8'd10)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // Model: an update sampled at edge S writes sec/min/hour
    // at S+1..S+3, pulses done after S+3, may resample at S+5.
    int          e;
    int          m_s;
    int          p;
    int          q;
    int          op;
    int          k;
    logic [7:0]  sn_h, sn_m, sn_s;
    logic [23:0] m_bcd;
    logic [23:0] prev;
    logic        m_upd, m_err;
    logic [7:0]  m_conv;
    logic [5:0]  m_an;
    logic [3:0]  m_digit;

    task automatic model_reset();
        e = 0; m_s = -100;
        sn_h = 8'hFF; sn_m = 8'hFF; sn_s = 8'hFF;
        m_bcd = 24'd0; m_upd = 1'b0; m_err = 1'b0;
        m_conv = 8'd0; m_an = 6'b111111; m_digit = 4'd0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                model_reset();
            end else begin
                e++;
                prev = m_bcd;
                p = e - m_s;
                if (p >= 1 && p <= 3) begin
                    op = (p == 1) ? int'(sn_s) :
                         (p == 2) ? int'(sn_m) : int'(sn_h);
                    if (op > 99) begin
                        m_err = 1'b1;
                        op = 99;
                    end
                    m_bcd[8*(p-1) +: 8] = bcd8(op);
                end
                m_upd = (p == 3);
                if (p >= 5 && {bus.hour, bus.min, bus.sec} !=
                              {sn_h, sn_m, sn_s}) begin
                    m_s = e;
                    sn_h = bus.hour;
                    sn_m = bus.min;
                    sn_s = bus.sec;
                end
                q = e - m_s;
                op = (q == 0) ? int'(sn_s) :
                     (q == 1) ? int'(sn_m) :
                     (q == 2) ? int'(sn_h) : 0;
                m_conv = (op > 99) ? 8'd99 : 8'(op);
                if (e % D == 0) begin
                    k = (e / D - 1) % 6;
                    m_an = ~(6'b000001 << k);
                    m_digit = 4'(prev >> (4 * k));
                end
            end
            chk("conv_bin", 32'(bus.conv_bin), 32'(m_conv));
            chk("bcd_hms", 32'(bus.bcd_hms), 32'(m_bcd));
            chk("upd_done", 32'(bus.upd_done), 32'(m_upd));
            chk("range_err", 32'(bus.range_err), 32'(m_err));
            chk("an", 32'(bus.an), 32'(m_an));
            chk("digit", 32'(bus.digit), 32'(m_digit));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_in(input int h, input int m, input int s);
        bus.hour = 8'(h);
        bus.min  = 8'(m);
        bus.sec  = 8'(s);
    endtask

    int         pulses;
    int         nz;
    bit         found;
    logic [5:0] an_exp [7];
    logic [3:0] dg_exp [7];

    initial begin
        n_total = 0;
        n_bad = 0;
        an_exp = '{6'b111110, 6'b111101, 6'b111011, 6'b110111,
                   6'b101111, 6'b011111, 6'b111110};
        dg_exp = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2, 4'd9};
        rst_n = 1'b0;
        set_in(12, 34, 56);
        tick(3);
        chk("rst_an", 32'(bus.an), 32'h3F);
        chk("rst_bcd", 32'(bus.bcd_hms), 32'h0);
        chk("rst_conv", 32'(bus.conv_bin), 32'h0);
        rst_n = 1'b1;

        tick(1);
        chk("seq_s", 32'(bus.conv_bin), 32'd56);
        tick(1);
        chk("seq_m", 32'(bus.conv_bin), 32'd34);
        tick(1);
        chk("seq_h", 32'(bus.conv_bin), 32'd12);
        tick(1);
        chk("first_bcd", 32'(bus.bcd_hms), 32'h123456);
        chk("first_upd", 32'(bus.upd_done), 32'd1);
        chk("model_pin", 32'(m_bcd), 32'h123456);
        tick(1);
        chk("upd_width", 32'(bus.upd_done), 32'd0);

        pulses = 0;
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.upd_done) pulses++;
            if (bus.conv_bin != 8'd0) nz++;
        end
        chk("hold_pulses", 32'(pulses), 32'd0);
        chk("hold_conv", 32'(nz), 32'd0);

        set_in(12, 0, 56);
        tick(5);
        chk("min0_bcd", 32'(bus.bcd_hms), 32'h120056);
        tick(1);
        set_in(12, 34, 56);
        tick(2);
        set_in(12, 34, 57);
        tick(2);
        chk("race_cur", 32'(bus.bcd_hms), 32'h123456);
        chk("race_upd1", 32'(bus.upd_done), 32'd1);
        tick(5);
        chk("race_next", 32'(bus.bcd_hms), 32'h123457);
        chk("race_upd2", 32'(bus.upd_done), 32'd1);

        set_in(23, 59, 59);
        tick(6);
        chk("scan_bcd", 32'(bus.bcd_hms), 32'h235959);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (bus.an == 6'b111110) found = 1'b1;
        end
        chk("scan_found", 32'(found), 32'd1);
        for (int i = 0; i < 7; i++) begin
            chk("scan_an", 32'(bus.an), 32'(an_exp[i]));
            chk("scan_dig", 32'(bus.digit), 32'(dg_exp[i]));
            tick(D);
        end

        set_in(23, 59, 150);
        tick(1);
        chk("clamp_conv", 32'(bus.conv_bin), 32'd99);
        tick(3);
        chk("clamp_bcd", 32'(bus.bcd_hms), 32'h235999);
        chk("clamp_err", 32'(bus.range_err), 32'd1);
        set_in(23, 59, 10);
        tick(6);
        chk("sticky_bcd", 32'(bus.bcd_hms), 32'h235910);
        chk("sticky_err", 32'(bus.range_err), 32'd1);

        set_in(23, 59, 20);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("mid_bcd", 32'(bus.bcd_hms), 32'h0);
        chk("mid_an", 32'(bus.an), 32'h3F);
        chk("mid_upd", 32'(bus.upd_done), 32'd0);
        chk("mid_err", 32'(bus.range_err), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("rerun_bcd", 32'(bus.bcd_hms), 32'h235920);
        chk("rerun_upd", 32'(bus.upd_done), 32'd1);
        tick(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
